pwm_multi: RTL and testbench
============================

// Module: pwm_multi
// PURPOSE
//   N-channel PWM generator sharing one free-running WIDTH-bit period counter.
//   Per-channel target duty is written through one indexed port. The active
//   duty is updated only at period boundaries, so outputs never glitch.
//   Optional per-period fading steps the active duty toward the target.
//   Drives LCD backlight and RGB indicator LEDs.
// PARAMETERS
//   WIDTH      8    counter/duty width; period = 2**WIDTH cycles
//   CHANNELS   3    number of PWM outputs (>=1)
//   FADE_STEP  16   duty change per period when fading (1..2**WIDTH-1)
//   INVERT     0    CHANNELS-bit mask; set bit = active-low output
// PORTS
//   i_clk       in   1               clock
//   i_reset     in   1               synchronous, active-high reset
//   i_write     in   1               strobe: load i_target into target[i_channel]
//   i_channel   in   max(1,clog2(CH)) channel index for the write
//   i_target    in   WIDTH           new target duty
//   i_fade_en   in   1               1 = fade at FADE_STEP/period; 0 = jump to target
//   o_pwm       out  CHANNELS        PWM outputs (XOR INVERT)
//   o_sync      out  1               high in the first cycle of each period (counter==0)
//   o_busy      out  1               high while any duty[ch] != target[ch]
// BEHAVIOUR
//   - Reset: counter=0, target[*]=0, duty[*]=0. Outputs: o_pwm=INVERT,
//     o_sync=1, o_busy=0. Reset overrides a simultaneous write.
//   - Counter: +1 every cycle, wraps from 2**WIDTH-1 to 0.
//   - Write: if i_write and i_channel<CHANNELS, target[i_channel]<=i_target on that
//     edge. Writes with an out-of-range index are ignored. Last write wins.
//   - Period end: the cycle with counter==2**WIDTH-1. At that edge, every duty[ch]
//     updates from the target value held before the edge:
//       fade off: duty<=target
//       fade on:  |target-duty|<=FADE_STEP ? duty<=target : duty<=duty+/-FADE_STEP
//       Compute in WIDTH+1 bits; never overshoot or wrap.
//   - A write in the period-end cycle is not used by that update. It applies at
//     the next period end (one full period of latency).
//   - Duty update latency: a write takes effect at the next period boundary.
//     Fading adds ceil(|delta|/FADE_STEP) periods.
//   - o_pwm[ch] = (counter < duty[ch]) ^ INVERT[ch], combinational from registers.
//       duty 0: never high.
//       duty 2**WIDTH-1: high 2**WIDTH-1 of 2**WIDTH cycles.
//       High phase starts at counter==0 (edge-aligned).
//   - i_fade_en is sampled at each period end. Changing it mid-fade affects the
//     next step only.
//   - o_busy = OR over ch of (duty[ch]!=target[ch]). Combinational.
//   - No other state. Behaviour is identical for every channel.
// TESTING  (WIDTH=8, CHANNELS=3, FADE_STEP=16, INVERT=0 unless noted)
//   1. Reset, write ch1=64, fade off. From the next counter==0, o_pwm[1] is high
//      for exactly 64 of every 256 cycles. o_pwm[0] and o_pwm[2] stay low.
//      o_sync pulses every 256 cycles.
//   2. Write ch0=200 at counter==10: o_pwm[0] is unchanged until the wrap.
//      Write at counter==255: the new duty appears only after the following wrap.
//   3. Fade on, ch2 0->100: duty per period is 16,32,48,64,80,96,100. o_busy
//      falls after the 100 step. Then 100->0: duty 84,...,4,0 with no wrap.
//   4. Duty 255 gives high 255/256 cycles. Duty 0 gives constant low.
//      With INVERT=3'b010, ch1 is the complement and ch1 is high during reset.
//   5. Write with i_channel=3: no target changes, o_busy stays 0.
//   6. Assert reset mid-fade at counter==77: after release, counter=0, o_sync=1,
//      all duty/target=0, o_busy=0.

Source files
------------

// File: rtl/pwm_multi.sv
// N-channel PWM generator sharing one free-running period counter.
// Duty changes land only at period boundaries, optionally fading toward the target.
module pwm_multi #(
    parameter int                  WIDTH     = 8,
    parameter int                  CHANNELS  = 3,
    parameter int                  FADE_STEP = 16,
    parameter logic [CHANNELS-1:0] INVERT    = '0,
    localparam int                 CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_write,
    input  logic [CH_W-1:0]     i_channel,
    input  logic [WIDTH-1:0]    i_target,
    input  logic                i_fade_en,
    output logic [CHANNELS-1:0] o_pwm,
    output logic                o_sync,
    output logic                o_busy
);

    localparam logic [WIDTH:0] STEP = (WIDTH + 1)'(FADE_STEP);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_target    [CHANNELS];
    logic [WIDTH-1:0] r_duty      [CHANNELS];
    logic [WIDTH-1:0] w_next_duty [CHANNELS];
    logic [WIDTH:0]   w_diff      [CHANNELS];
    logic [WIDTH:0]   w_sum       [CHANNELS];
    logic             w_period_end;

    assign w_period_end = (r_count == '1);

    // Fading: move by STEP unless the target is within one step, so duty never overshoots.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_next_duty[ch] = r_target[ch];
            w_diff[ch]      = '0;
            w_sum[ch]       = '0;
            if (i_fade_en) begin
                if (r_target[ch] >= r_duty[ch]) begin
                    w_diff[ch] = {1'b0, r_target[ch]} - {1'b0, r_duty[ch]};
                    w_sum[ch]  = {1'b0, r_duty[ch]} + STEP;
                end else begin
                    w_diff[ch] = {1'b0, r_duty[ch]} - {1'b0, r_target[ch]};
                    w_sum[ch]  = {1'b0, r_duty[ch]} - STEP;
                end
                if (w_diff[ch] > STEP) begin
                    w_next_duty[ch] = w_sum[ch][WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_target[ch] <= '0;
                r_duty[ch]   <= '0;
            end
        end else begin
            r_count <= r_count + 1'b1;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (i_write && (i_channel == CH_W'(ch))) begin
                    r_target[ch] <= i_target;
                end
                if (w_period_end) begin
                    r_duty[ch] <= w_next_duty[ch];
                end
            end
        end
    end

    always_comb begin
        o_pwm  = '0;
        o_busy = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            o_pwm[ch] = (r_count < r_duty[ch]) ^ INVERT[ch];
            if (r_duty[ch] != r_target[ch]) begin
                o_busy = 1'b1;
            end
        end
    end

    assign o_sync = (r_count == '0);

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: stimulus pushes per-period expected high counts,
// a monitor measures each period between o_sync pulses and compares.
module tb_pwm_multi;

    typedef struct {
        int    e0;
        int    e1;
        int    e2;
        bit    busy;
        string name;
    } expT;

    logic       clock = 1'b0;
    logic       reset;
    logic       write;
    logic [1:0] channel;
    logic [7:0] target;
    logic       fadeEn;
    logic [2:0] pwm;
    logic       sync;
    logic       busy;
    logic [2:0] pwmInv;
    logic       syncInv;
    logic       busyInv;

    int  checks   = 0;
    int  failures = 0;
    expT expQ[$];

    int upSteps[6]   = '{16, 32, 48, 64, 80, 96};
    int downSteps[6] = '{84, 68, 52, 36, 20, 4};

    always #5 clock = ~clock;

    pwm_multi dut (
        .i_clk     (clock),
        .i_reset   (reset),
        .i_write   (write),
        .i_channel (channel),
        .i_target  (target),
        .i_fade_en (fadeEn),
        .o_pwm     (pwm),
        .o_sync    (sync),
        .o_busy    (busy)
    );

    pwm_multi #(.INVERT(3'b010)) dutInv (
        .i_clk     (clock),
        .i_reset   (reset),
        .i_write   (write),
        .i_channel (channel),
        .i_target  (target),
        .i_fade_en (fadeEn),
        .o_pwm     (pwmInv),
        .o_sync    (syncInv),
        .o_busy    (busyInv)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput($sformatf("%s_pwm", tag), int'(pwm), 0);
        checkOutput($sformatf("%s_sync", tag), int'(sync), 1);
        checkOutput($sformatf("%s_busy", tag), int'(busy), 0);
        checkOutput($sformatf("%s_pwm_inv", tag), int'(pwmInv), 2);
    endtask

    // Advance at least one cycle, then up to a bounded number until the next period start.
    task automatic waitSync();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sync && n < 600);
        checkOutput("sync_seen", int'(sync), 1);
    endtask

    // Called at the negedge of a counter==0 cycle; runs one full period with an optional write.
    task automatic applyStimulus(input string name, input int e0, input int e1, input int e2,
                                 input bit eBusy, input bit doWrite, input int offset,
                                 input int wrCh, input int wrVal);
        expT ex;
        ex.e0   = e0;
        ex.e1   = e1;
        ex.e2   = e2;
        ex.busy = eBusy;
        ex.name = name;
        expQ.push_back(ex);
        for (int c = 0; c < 256; c++) begin
            write   = doWrite && (c == offset);
            channel = wrCh[1:0];
            target  = wrVal[7:0];
            @(negedge clock);
        end
        write = 1'b0;
    endtask

    // Monitor: measures high cycles per channel over each period and checks it against the queue.
    initial begin
        int  cnt[3];
        int  cntInv;
        int  len;
        bit  active;
        bit  busyStart;
        expT ex;
        active = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (reset) begin
                active = 1'b0;
            end else if (sync) begin
                if (active) begin
                    checkOutput("period_len", len, 256);
                    if (expQ.size() > 0) begin
                        ex = expQ.pop_front();
                        checkOutput($sformatf("%s_ch0", ex.name), cnt[0], ex.e0);
                        checkOutput($sformatf("%s_ch1", ex.name), cnt[1], ex.e1);
                        checkOutput($sformatf("%s_ch2", ex.name), cnt[2], ex.e2);
                        checkOutput($sformatf("%s_ch1_inv", ex.name), cntInv, 256 - ex.e1);
                        checkOutput($sformatf("%s_busy", ex.name), int'(busyStart), int'(ex.busy));
                    end
                end
                active    = 1'b1;
                len       = 1;
                busyStart = busy;
                cntInv    = int'(pwmInv[1]);
                for (int i = 0; i < 3; i++) cnt[i] = int'(pwm[i]);
            end else if (active) begin
                len++;
                cntInv += int'(pwmInv[1]);
                for (int i = 0; i < 3; i++) cnt[i] += int'(pwm[i]);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        write   = 1'b0;
        channel = '0;
        target  = '0;
        fadeEn  = 1'b0;
        repeat (3) @(negedge clock);
        checkResetState("reset");

        // A write coinciding with reset must be dropped.
        write   = 1'b1;
        channel = 2'd0;
        target  = 8'd77;
        @(negedge clock);
        write = 1'b0;
        reset = 1'b0;
        #1;
        checkResetState("release");
        waitSync();

        applyStimulus("idle_wr1", 0, 0, 0, 0, 1, 5, 1, 64);
        applyStimulus("ch1_64_wr3", 0, 64, 0, 0, 1, 20, 3, 99);
        applyStimulus("ch1_64", 0, 64, 0, 0, 0, 0, 0, 0);

        applyStimulus("mid_wr0", 0, 64, 0, 0, 1, 10, 0, 200);
        applyStimulus("end_wr0", 200, 64, 0, 0, 1, 255, 0, 50);
        applyStimulus("late_hold", 200, 64, 0, 1, 0, 0, 0, 0);
        applyStimulus("late_apply", 50, 64, 0, 0, 0, 0, 0, 0);

        fadeEn = 1'b1;
        applyStimulus("fade_start", 50, 64, 0, 0, 1, 0, 2, 100);
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("fade_up%0d", i), 50, 64, upSteps[i], 1, 0, 0, 0, 0);
        end
        applyStimulus("fade_top", 50, 64, 100, 0, 1, 0, 2, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("fade_dn%0d", i), 50, 64, downSteps[i], 1, 0, 0, 0, 0);
        end
        applyStimulus("fade_zero", 50, 64, 0, 0, 0, 0, 0, 0);

        fadeEn = 1'b0;
        applyStimulus("wr_max", 50, 64, 0, 0, 1, 3, 0, 255);
        applyStimulus("duty_max", 255, 64, 0, 0, 1, 3, 1, 0);
        applyStimulus("duty_zero", 255, 0, 0, 0, 0, 0, 0, 0);

        fadeEn = 1'b1;
        applyStimulus("fade2_start", 255, 0, 0, 0, 1, 0, 2, 200);
        applyStimulus("fade2_step", 255, 0, 16, 1, 0, 0, 0, 0);

        for (int c = 0; c < 77; c++) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checkResetState("midfade");
        waitSync();
        applyStimulus("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        checkOutput("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
